runway_scheduler: RTL

Parametrised N-runway clearance scheduler for the BobATC tower. It queues takeoff and landing requests in separate per-kind FIFOs and locks free runways to the plane at the head of a queue. It presents each clearance on a valid/ready handshake and unlocks a runway only when the owning plane releases it. It sits between the request decoder and the reply generator, and replaces the fixed two-runway lock logic.

---
 rtl/runway_pkg.sv | 35 +++
 rtl/runway_scheduler_if.sv | 41 ++++
 rtl/plane_queue.sv | 58 +++++
 rtl/runway_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/runway_pkg.sv
// Shared types for the runway clearance scheduler.
package runway_pkg;

    // Storage width for plane IDs held in runway slots. ID_W must not exceed it.
    localparam int ID_MAX_W = 16;
    // Widest runway index (eight runways).
    localparam int RW_MAX_W = 3;

    typedef enum logic {
        K_TAKEOFF = 1'b0,
        K_LANDING = 1'b1
    } plane_kind_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] owner;
        logic                active;
    } runway_slot_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        plane_kind_t         kind;
        logic [RW_MAX_W-1:0] runway;
    } clearance_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } sched_state_t;

    // Runway index width; a single runway still needs one bit.
    function automatic int rw_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/runway_scheduler_if.sv
// Request / release / clearance bundle between decoder, scheduler and reply path.
interface runway_scheduler_if
    import runway_pkg::*;
#(
    parameter int NUM_RUNWAYS = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int ID_W        = 4
);
    localparam int RW_W  = rw_width(NUM_RUNWAYS);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic                   req_valid;
    logic                   req_kind;
    logic [ID_W-1:0]        req_id;
    logic                   req_reject;
    logic                   rel_valid;
    logic [ID_W-1:0]        rel_id;
    logic [RW_W-1:0]        rel_runway;
    logic                   rel_error;
    logic                   clr_valid;
    logic                   clr_ready;
    logic [ID_W-1:0]        clr_id;
    logic                   clr_kind;
    logic [RW_W-1:0]        clr_runway;
    logic [NUM_RUNWAYS-1:0] runway_busy;
    logic [CNT_W-1:0]       takeoff_count;
    logic [CNT_W-1:0]       landing_count;

    modport master (
        output req_valid, req_kind, req_id, rel_valid, rel_id, rel_runway, clr_ready,
        input  req_reject, rel_error, clr_valid, clr_id, clr_kind, clr_runway,
               runway_busy, takeoff_count, landing_count
    );

    modport slave (
        input  req_valid, req_kind, req_id, rel_valid, rel_id, rel_runway, clr_ready,
        output req_reject, rel_error, clr_valid, clr_id, clr_kind, clr_runway,
               runway_busy, takeoff_count, landing_count
    );

endinterface

// File: rtl/plane_queue.sv
// Power-of-two FIFO for waiting planes. Push is ignored when full, pop when empty.
module plane_queue #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    // Full/empty come from the registered count, so a same-edge pop never makes room.
    always_comb begin
        push_ok = push && (cnt_q != CNT_W'(DEPTH));
        pop_ok  = pop && (cnt_q != '0);
        wr_d    = push_ok ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop_ok  ? rd_q + PTR_W'(1) : rd_q;
        cnt_d   = cnt_q;
        if (push_ok && !pop_ok) cnt_d = cnt_q + CNT_W'(1);
        if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_W'(1);
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset; the count guards every read.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_q] <= din;
    end

    assign dout  = mem[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/runway_scheduler.sv
// N-runway clearance scheduler: per-kind queues, runway locks, valid/ready clearances.
// Build option RUNWAY_LANDING_PRIORITY_EN: landings beat takeoffs when both queues wait;
// otherwise the kinds alternate using the last-served flag.
module runway_scheduler
    import runway_pkg::*;
#(
    parameter int NUM_RUNWAYS = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int ID_W        = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    runway_scheduler_if.slave bus
);
    localparam int RW_W  = rw_width(NUM_RUNWAYS);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    sched_state_t           state_q, state_d;
    plane_kind_t            last_q, last_d, pick;
    runway_slot_t           slots_q [NUM_RUNWAYS];
    runway_slot_t           slots_d [NUM_RUNWAYS];
    logic [ID_W-1:0]        clr_id_q, clr_id_d;
    plane_kind_t            clr_kind_q, clr_kind_d;
    logic [RW_W-1:0]        clr_rw_q, clr_rw_d;
    logic                   rej_q, rej_d, err_q, err_d;

    logic                   to_full, to_empty, ld_full, ld_empty;
    logic [ID_W-1:0]        to_head, ld_head;
    logic [CNT_W-1:0]       to_cnt, ld_cnt;
    logic                   to_push, ld_push, to_pop, ld_pop;

    logic [NUM_RUNWAYS-1:0] free_vec, lock_vec, rel_hit, busy;
    logic [RW_W-1:0]        lock_idx;
    logic                   any_free, start, rel_ok;

    plane_queue #(.WIDTH(ID_W), .DEPTH(QUEUE_DEPTH)) u_takeoff_q (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (to_push),
        .pop     (to_pop),
        .din     (bus.req_id),
        .dout    (to_head),
        .count   (to_cnt),
        .full    (to_full),
        .empty   (to_empty)
    );

    plane_queue #(.WIDTH(ID_W), .DEPTH(QUEUE_DEPTH)) u_landing_q (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (ld_push),
        .pop     (ld_pop),
        .din     (bus.req_id),
        .dout    (ld_head),
        .count   (ld_cnt),
        .full    (ld_full),
        .empty   (ld_empty)
    );

    // Lowest free runway and release match, done by index compare so an
    // out-of-range rel_runway simply matches nothing.
    always_comb begin
        free_vec = '0;
        lock_vec = '0;
        rel_hit  = '0;
        busy     = '0;
        lock_idx = '0;
        for (int i = NUM_RUNWAYS - 1; i >= 0; i--) begin
            free_vec[i] = !slots_q[i].active;
            busy[i]     = slots_q[i].active;
            if (!slots_q[i].active) lock_idx = RW_W'(i);
            rel_hit[i]  = (bus.rel_runway == RW_W'(i)) && slots_q[i].active &&
                          (slots_q[i].owner == ID_MAX_W'(bus.rel_id));
        end
        for (int i = 0; i < NUM_RUNWAYS; i++)
            lock_vec[i] = free_vec[i] && (lock_idx == RW_W'(i));
        any_free = |free_vec;
        rel_ok   = bus.rel_valid && (|rel_hit);
    end

    // Which queue to serve when a runway can be handed out.
    always_comb begin
        pick = K_TAKEOFF;
        if (!to_empty && !ld_empty) begin
`ifdef RUNWAY_LANDING_PRIORITY_EN
            pick = K_LANDING;
`else
            pick = (last_q == K_LANDING) ? K_TAKEOFF : K_LANDING;
`endif
        end else if (!ld_empty) begin
            pick = K_LANDING;
        end
        start = (state_q == S_IDLE) && any_free && (!to_empty || !ld_empty);
    end

    // FSM next state, queue pops and the clearance captured at the lock.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        clr_id_d   = clr_id_q;
        clr_kind_d = clr_kind_q;
        clr_rw_d   = clr_rw_q;
        to_pop     = 1'b0;
        ld_pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_OFFER;
                    last_d     = pick;
                    to_pop     = (pick == K_TAKEOFF);
                    ld_pop     = (pick == K_LANDING);
                    clr_id_d   = (pick == K_LANDING) ? ld_head : to_head;
                    clr_kind_d = pick;
                    clr_rw_d   = lock_idx;
                end
            end
            S_OFFER: begin
                if (bus.clr_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Runway locks: release and a new lock can land on the same edge (different runways).
    always_comb begin
        for (int i = 0; i < NUM_RUNWAYS; i++) begin
            slots_d[i] = slots_q[i];
            if (rel_ok && rel_hit[i]) slots_d[i].active = 1'b0;
            if (start && lock_vec[i]) begin
                slots_d[i].active = 1'b1;
                slots_d[i].owner  = ID_MAX_W'(clr_id_d);
            end
        end
    end

    // Enqueue and error pulses; full is sampled before the edge.
    always_comb begin
        to_push = bus.req_valid && (bus.req_kind == K_TAKEOFF);
        ld_push = bus.req_valid && (bus.req_kind == K_LANDING);
        rej_d   = bus.req_valid && ((bus.req_kind == K_LANDING) ? ld_full : to_full);
        err_d   = bus.rel_valid && !rel_ok;
    end

    // Scheduler state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            last_q     <= K_LANDING;
            clr_id_q   <= '0;
            clr_kind_q <= K_TAKEOFF;
            clr_rw_q   <= '0;
            rej_q      <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_RUNWAYS; i++) slots_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            clr_id_q   <= clr_id_d;
            clr_kind_q <= clr_kind_d;
            clr_rw_q   <= clr_rw_d;
            rej_q      <= rej_d;
            err_q      <= err_d;
            for (int i = 0; i < NUM_RUNWAYS; i++) slots_q[i] <= slots_d[i];
        end
    end

    assign bus.clr_valid     = (state_q == S_OFFER);
    assign bus.clr_id        = clr_id_q;
    assign bus.clr_kind      = clr_kind_q;
    assign bus.clr_runway    = clr_rw_q;
    assign bus.runway_busy   = busy;
    assign bus.req_reject    = rej_q;
    assign bus.rel_error     = err_q;
    assign bus.takeoff_count = to_cnt;
    assign bus.landing_count = ld_cnt;

endmodule
